cbfp_denorm: RTL and testbench

CBFP_DENORM -- requirements
Module: cbfp_denorm

---
 rtl/cbfp_denorm.sv | 190 +++++++++++++++++++
 tb/tb_cbfp_denorm.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_denorm.sv
// cbfp_denorm: two-stage CBFP de-normalizer.
// S1 registers the sample and net shift; S2 applies the shift and saturates.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   in_valid / in_ready    input handshake
//   in_re, in_im           signed normalized sample (BW_IN)
//   in_idx0, in_idx1       unsigned CBFP indices (IDX_W)
//   out_valid / out_ready  output handshake
//   out_re, out_im         signed de-normalized sample (BW_OUT)
//   out_sat                either component clipped
//   out_last               output sample N-1 of the frame
//   frame_sat              sticky per-frame saturation flag
module cbfp_denorm #(
  parameter int N          = 512,
  parameter int BW_IN      = 11,
  parameter int BW_OUT     = 13,
  parameter int IDX_W      = 5,
  parameter int SHIFT_BIAS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BW_IN-1:0]  in_re,
  input  logic signed [BW_IN-1:0]  in_im,
  input  logic [IDX_W-1:0]         in_idx0,
  input  logic [IDX_W-1:0]         in_idx1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [BW_OUT-1:0] out_re,
  output logic signed [BW_OUT-1:0] out_im,
  output logic                     out_sat,
  output logic                     out_last,
  output logic                     frame_sat
);

  localparam int DW = IDX_W + 2;
  // The largest left shift is SHIFT_BIAS (both indices zero).
  localparam int WW = BW_IN + SHIFT_BIAS + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW-1:0] BIAS = DW'(SHIFT_BIAS);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic signed [WW-1:0] SMAX =
    {{(WW-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = ~SMAX;

  logic                     rdy_q, rdy_d;
  logic                     s1_vld_q, s1_vld_d;
  logic signed [BW_IN-1:0]  s1_re_q, s1_re_d;
  logic signed [BW_IN-1:0]  s1_im_q, s1_im_d;
  logic signed [DW-1:0]     s1_d_q, s1_d_d;
  logic                     s2_vld_q, s2_vld_d;
  logic signed [BW_OUT-1:0] s2_re_q, s2_re_d;
  logic signed [BW_OUT-1:0] s2_im_q, s2_im_d;
  logic                     s2_sat_q, s2_sat_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     fsat_q, fsat_d;
  logic                     clr_q, clr_d;

  logic          s2_en;
  logic          in_fire;
  logic          out_fire;
  logic [DW-1:0] idx_sum;
  logic [DW-1:0] d_in;
  logic [BW_OUT:0] re_res;
  logic [BW_OUT:0] im_res;

  // Returns {clipped, value}.
  function automatic logic [BW_OUT:0] denorm(
    input logic signed [BW_IN-1:0] x,
    input logic signed [DW-1:0]    d
  );
    logic signed [BW_OUT-1:0] r;
    logic signed [WW-1:0]     w;
    logic [DW-1:0]            sh;
    logic                     sat;
    r   = '0;
    w   = '0;
    sh  = '0;
    sat = 1'b0;
    if (!d[DW-1]) begin
      // Shifting past BW_IN leaves only sign bits: 0 or -1.
      sh = d;
      r  = {{(BW_OUT-BW_IN){x[BW_IN-1]}}, x};
      r  = r >>> sh;
    end else begin
      sh = -d;
      w  = {{(WW-BW_IN){x[BW_IN-1]}}, x};
      w  = w <<< sh;
      if (w > SMAX) begin
        r   = SMAX[BW_OUT-1:0];
        sat = 1'b1;
      end else if (w < SMIN) begin
        r   = SMIN[BW_OUT-1:0];
        sat = 1'b1;
      end else begin
        r = w[BW_OUT-1:0];
      end
    end
    return {sat, r};
  endfunction

  assign s2_en    = !s2_vld_q || out_ready;
  assign in_ready = rdy_q && (!s1_vld_q || s2_en);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_vld_q && out_ready;
  assign idx_sum  = {2'b00, in_idx0} + {2'b00, in_idx1};
  assign d_in     = idx_sum - BIAS;

  assign out_valid = s2_vld_q;
  assign out_re    = s2_re_q;
  assign out_im    = s2_im_q;
  assign out_sat   = s2_sat_q;
  assign out_last  = s2_vld_q && (cnt_q == LAST);
  assign frame_sat = fsat_q;

  always_comb begin
    rdy_d    = 1'b1;
    s1_vld_d = s1_vld_q;
    s1_re_d  = s1_re_q;
    s1_im_d  = s1_im_q;
    s1_d_d   = s1_d_q;
    s2_vld_d = s2_vld_q;
    s2_re_d  = s2_re_q;
    s2_im_d  = s2_im_q;
    s2_sat_d = s2_sat_q;
    cnt_d    = cnt_q;
    fsat_d   = fsat_q;
    clr_d    = clr_q;
    re_res   = denorm(s1_re_q, s1_d_q);
    im_res   = denorm(s1_im_q, s1_d_q);

    if (in_ready) s1_vld_d = in_valid;
    if (in_fire) begin
      s1_re_d = in_re;
      s1_im_d = in_im;
      s1_d_d  = d_in;
    end

    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_re_d  = re_res[BW_OUT-1:0];
        s2_im_d  = im_res[BW_OUT-1:0];
        s2_sat_d = re_res[BW_OUT] | im_res[BW_OUT];
      end
    end

    if (out_fire) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      // First transfer of a new frame restarts the sticky flag.
      fsat_d = clr_q ? s2_sat_q : (fsat_q | s2_sat_q);
      clr_d  = out_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_d_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_re_q  <= '0;
      s2_im_q  <= '0;
      s2_sat_q <= 1'b0;
      cnt_q    <= '0;
      fsat_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      s1_vld_q <= s1_vld_d;
      s1_re_q  <= s1_re_d;
      s1_im_q  <= s1_im_d;
      s1_d_q   <= s1_d_d;
      s2_vld_q <= s2_vld_d;
      s2_re_q  <= s2_re_d;
      s2_im_q  <= s2_im_d;
      s2_sat_q <= s2_sat_d;
      cnt_q    <= cnt_d;
      fsat_q   <= fsat_d;
      clr_q    <= clr_d;
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
// tb_cbfp_denorm: directed self-checking bench for cbfp_denorm.
// Each scenario task drives stimulus and checks against hand-computed values.
module tb_cbfp_denorm;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_re;
  logic signed [10:0] in_im;
  logic [4:0]         in_idx0;
  logic [4:0]         in_idx1;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_re;
  logic signed [12:0] out_im;
  logic               out_sat;
  logic               out_last;
  logic               frame_sat;

  int total = 0;
  int bad   = 0;

  cbfp_denorm #(
    .N(512), .BW_IN(11), .BW_OUT(13), .IDX_W(5), .SHIFT_BIAS(9)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .in_idx0(in_idx0), .in_idx1(in_idx1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_sat(out_sat), .out_last(out_last),
    .frame_sat(frame_sat)
  );

  always #5 clk = ~clk;

  // Present one sample; returns out_valid one edge after capture.
  // Leaves the bench #1 after the edge that loads S2.
  task automatic send1(input int re, input int im,
                       input int i0, input int i1,
                       output logic early);
    @(negedge clk);
    in_valid  = 1'b1;
    in_re     = 11'(re);
    in_im     = 11'(im);
    in_idx0   = 5'(i0);
    in_idx1   = 5'(i1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    early    = out_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; in_idx0 = '0; in_idx1 = '0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_re !== 0 ||
        out_im !== 0 || out_sat !== 1'b0 || out_last !== 1'b0 ||
        frame_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b vld=%b re=%0d im=%0d sat=%b last=%b fsat=%b want all 0",
               in_ready, out_valid, out_re, out_im, out_sat, out_last, frame_sat);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rdy_before_edge got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rdy_after_edge got=%b want=1", in_ready);
    end
  endtask

  task automatic test_frame_random();
    logic signed [10:0] re_m[512];
    logic signed [10:0] im_m[512];
    int sent = 0, rcv = 0, cyc = 0;
    logic ifire, ofire, exp_rdy;
    for (int i = 0; i < 512; i++) begin
      re_m[i] = 11'($urandom_range(0, 2047));
      im_m[i] = 11'($urandom_range(0, 2047));
    end
    while (rcv < 512 && cyc < 8000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 60);
      if (sent < 512 && $urandom_range(0, 99) < 80) begin
        in_valid = 1'b1; in_re = re_m[sent]; in_im = im_m[sent];
        in_idx0 = 5'd0; in_idx1 = 5'd9;
      end else begin
        in_valid = 1'b0; in_re = 11'($urandom); in_im = 11'($urandom);
        in_idx0 = 5'($urandom); in_idx1 = 5'($urandom);
      end
      #1;
      exp_rdy = !((sent - rcv) == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
      end
      if (out_valid) begin
        total++;
        if (rcv >= sent || out_re !== re_m[rcv] || out_im !== im_m[rcv] ||
            out_sat !== 1'b0 || out_last !== (rcv == 511)) begin
          bad++;
          $display("FAIL rand_out n=%0d got re=%0d im=%0d last=%b sat=%b want re=%0d im=%0d last=%b sat=0",
                   rcv, out_re, out_im, out_last, out_sat,
                   re_m[rcv], im_m[rcv], (rcv == 511));
        end
      end
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      @(posedge clk);
      if (ifire) sent++;
      if (ofire) rcv++;
      cyc++;
    end
    #1;
    total++;
    if (rcv != 512 || frame_sat !== 1'b0) begin
      bad++;
      $display("FAIL rand_done got rcv=%0d fsat=%b want rcv=512 fsat=0", rcv, frame_sat);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_unity();
    logic early;
    send1(100, -7, 0, 9, early);
    total++;
    if (early !== 1'b0 || out_valid !== 1'b1 || out_re !== 100 ||
        out_im !== -7 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL unity got early=%b vld=%b re=%0d im=%0d sat=%b want 0 1 100 -7 0",
               early, out_valid, out_re, out_im, out_sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_right_shift();
    logic early;
    send1(-100, 100, 3, 9, early);
    total++;
    if (out_valid !== 1'b1 || out_re !== -13 || out_im !== 12 ||
        out_sat !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rshift got vld=%b re=%0d im=%0d sat=%b last=%b want 1 -13 12 0 0",
               out_valid, out_re, out_im, out_sat, out_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_big_shift();
    logic early;
    send1(-1, 5, 31, 31, early);
    total++;
    if (out_valid !== 1'b1 || out_re !== -1 || out_im !== 0 ||
        out_sat !== 1'b0) begin
      bad++;
      $display("FAIL bigshift got vld=%b re=%0d im=%0d sat=%b want 1 -1 0 0",
               out_valid, out_re, out_im, out_sat);
    end
    @(posedge clk); #1;
  endtask

  // Saturating sample is frame index 3; finish the frame, then check clear.
  task automatic test_sat_frame();
    logic early, ofire, ifire;
    logic signed [10:0] ev;
    int sent = 0, rcv = 0, cyc = 0;
    send1(300, -300, 0, 5, early);
    total++;
    if (out_re !== 4095 || out_im !== -4096 || out_sat !== 1'b1 ||
        frame_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_out got re=%0d im=%0d sat=%b fsat=%b want 4095 -4096 1 0",
               out_re, out_im, out_sat, frame_sat);
    end
    @(posedge clk); #1;
    total++;
    if (frame_sat !== 1'b1) begin
      bad++; $display("FAIL sat_sticky got=%b want=1", frame_sat);
    end
    while (rcv < 508 && cyc < 2000) begin
      @(negedge clk);
      in_valid = (sent < 508); in_re = 11'(sent); in_im = 11'(-sent);
      in_idx0 = 5'd0; in_idx1 = 5'd9; out_ready = 1'b1;
      #1;
      ofire = out_valid && out_ready;
      ifire = in_valid && in_ready;
      if (ofire) begin
        ev = 11'(rcv);
        total++;
        if (out_re !== ev || out_im !== -ev || frame_sat !== 1'b1 ||
            out_last !== (rcv == 507)) begin
          bad++;
          $display("FAIL sat_frame n=%0d got re=%0d im=%0d fsat=%b last=%b want re=%0d im=%0d fsat=1 last=%b",
                   rcv, out_re, out_im, frame_sat, out_last, ev, -ev, (rcv == 507));
        end
      end
      @(posedge clk);
      if (ifire) sent++;
      if (ofire) rcv++;
      cyc++;
    end
    #1;
    total++;
    if (rcv != 508 || frame_sat !== 1'b1) begin
      bad++;
      $display("FAIL sat_after_last got rcv=%0d fsat=%b want 508 1", rcv, frame_sat);
    end
    send1(1, 1, 0, 9, early);
    total++;
    if (out_last !== 1'b0 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_newframe got last=%b sat=%b want 0 0", out_last, out_sat);
    end
    @(posedge clk); #1;
    total++;
    if (frame_sat !== 1'b0) begin
      bad++; $display("FAIL sat_clear got=%b want=0", frame_sat);
    end
  endtask

  // Frame counter enters at 1; reset at output 200 with both stages full.
  task automatic test_reset_mid();
    logic ofire, ifire;
    logic signed [10:0] ev;
    int sent = 0, rcv = 0, cyc = 0;
    while (rcv < 200 && cyc < 1000) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = 11'(sent + 300); in_im = 11'(sent);
      in_idx0 = 5'd4; in_idx1 = 5'd5; out_ready = 1'b1;
      #1;
      ofire = out_valid && out_ready;
      ifire = in_valid && in_ready;
      if (ofire) begin
        ev = 11'(rcv + 300);
        total++;
        if (out_re !== ev || out_last !== 1'b0) begin
          bad++;
          $display("FAIL pre_rst n=%0d got re=%0d last=%b want re=%0d last=0",
                   rcv, out_re, out_last, ev);
        end
      end
      @(posedge clk);
      if (ifire) sent++;
      if (ofire) rcv++;
      cyc++;
    end
    @(negedge clk); out_ready = 1'b0; #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_stall got rdy=%b vld=%b want 0 1", in_ready, out_valid);
    end
    rst = 1'b1; in_valid = 1'b0; #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 ||
        out_re !== 0) begin
      bad++;
      $display("FAIL rst_async got vld=%b rdy=%b last=%b re=%0d want 0 0 0 0",
               out_valid, in_ready, out_last, out_re);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 512 && cyc < 2000) begin
      @(negedge clk);
      in_valid = (sent < 512); in_re = 11'(sent); in_im = 11'(-sent);
      in_idx0 = 5'd0; in_idx1 = 5'd9; out_ready = 1'b1;
      #1;
      ofire = out_valid && out_ready;
      ifire = in_valid && in_ready;
      if (ofire) begin
        ev = 11'(rcv);
        total++;
        if (out_re !== ev || out_im !== -ev || out_last !== (rcv == 511)) begin
          bad++;
          $display("FAIL post_rst n=%0d got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                   rcv, out_re, out_im, out_last, ev, -ev, (rcv == 511));
        end
      end
      @(posedge clk);
      if (ifire) sent++;
      if (ofire) rcv++;
      cyc++;
    end
    #1;
    total++;
    if (rcv != 512 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_done got rcv=%0d vld=%b want 512 0", rcv, out_valid);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_random();
    test_unity();
    test_right_shift();
    test_big_shift();
    test_sat_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
